// File: rtl/registro_flota.sv
// registro_flota: fleet register for the battleship datapath.
// Holds NUM_BARCOS ships of up to MAX_LEN cells each.  Runs three phases:
// placement (one cell per request, with range/overlap/fill checks), attack
// (hit/miss, per-ship sunk tracking, repeat-shot detection) and game over.
// Every request resolves with a registered pulse on the following cycle.
//
// Optional build macro: CONTIGUITY_CHECK_EN -- when defined, each non-first
// cell of a ship must be orthogonally adjacent to that ship's previously
// accepted cell (same row +-1, or +-COLS).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   place_valid/barco/casilla/tipo -> place_ok / place_err pulses
//   attack_valid/casilla           -> attack_done, hit, repeat_shot, sunk, sunk_id
//   barcos_hundidos     sunk bitmask, one bit per ship
//   fase                00 PLACE, 01 PLAY, 10 OVER
//   all_sunk            high while in OVER
//
// state | meaning
// PLACE | accepting ship cells; leaves when every ship is complete
// PLAY  | accepting shots; leaves when every ship is sunk
// OVER  | game finished; holds until rst
module registro_flota #(
    parameter int NUM_BARCOS = 3,
    parameter int MAX_LEN    = 5,
    parameter int NUM_CELLS  = 25,
    parameter int COLS       = 5,
    parameter int CELL_W     = 5,
    parameter int ID_W       = (NUM_BARCOS > 1) ? $clog2(NUM_BARCOS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  place_valid,
    input  logic [ID_W-1:0]       place_barco,
    input  logic [CELL_W-1:0]     place_casilla,
    input  logic [2:0]            tipo,
    output logic                  place_ok,
    output logic                  place_err,
    input  logic                  attack_valid,
    input  logic [CELL_W-1:0]     attack_casilla,
    output logic                  attack_done,
    output logic                  hit,
    output logic                  repeat_shot,
    output logic                  sunk,
    output logic [ID_W-1:0]       sunk_id,
    output logic [NUM_BARCOS-1:0] barcos_hundidos,
    output logic [1:0]            fase,
    output logic                  all_sunk
);

    typedef enum logic [1:0] {PLACE = 2'b00, PLAY = 2'b01, OVER = 2'b10} fase_t;

    if ((2 ** CELL_W) < NUM_CELLS || COLS < 1) begin : g_bad_cfg
        $error("registro_flota: CELL_W too narrow for NUM_CELLS or COLS < 1");
    end

    fase_t                st;
    logic [2:0]           len_q  [NUM_BARCOS];
    logic [2:0]           fill_q [NUM_BARCOS];
    logic [CELL_W-1:0]    cell_q [NUM_BARCOS][MAX_LEN];
    logic [MAX_LEN-1:0]   hit_q  [NUM_BARCOS];
    logic [NUM_CELLS-1:0] occ_q;
    logic [NUM_CELLS-1:0] att_q;

    assign fase = st;

    // Placement decode
    logic       p_in_rng, p_occ, p_first, p_full, p_tipo_bad, p_adj_bad, p_err;
    logic [2:0] sel_len, sel_fill;
    logic       all_placed;

`ifdef CONTIGUITY_CHECK_EN
    logic [CELL_W-1:0] prev_cell;
    int                pc_i, pv_i;
`endif

    always_comb begin
        sel_len    = '0;
        sel_fill   = '0;
        p_occ      = 1'b0;
        all_placed = 1'b1;
        p_adj_bad  = 1'b0;
`ifdef CONTIGUITY_CHECK_EN
        prev_cell  = '0;
`endif
        p_in_rng = (int'(place_barco) < NUM_BARCOS) && (int'(place_casilla) < NUM_CELLS);
        for (int b = 0; b < NUM_BARCOS; b++) begin
            if (len_q[b] == 3'd0 || fill_q[b] != len_q[b])
                all_placed = 1'b0;
            if (place_barco == ID_W'(b)) begin
                sel_len  = len_q[b];
                sel_fill = fill_q[b];
`ifdef CONTIGUITY_CHECK_EN
                if (fill_q[b] != 3'd0)
                    prev_cell = cell_q[b][fill_q[b] - 3'd1];
`endif
            end
        end
        for (int c = 0; c < NUM_CELLS; c++)
            if (place_casilla == CELL_W'(c))
                p_occ = occ_q[c];
        p_first    = (sel_fill == 3'd0);
        // a ship with len 0 has never been started, so fill==len is not "full"
        p_full     = !p_first && (sel_fill == sel_len);
        p_tipo_bad = p_first && (tipo == 3'd0 || int'(tipo) > MAX_LEN);
`ifdef CONTIGUITY_CHECK_EN
        pc_i = int'(place_casilla);
        pv_i = int'(prev_cell);
        if (!p_first)
            p_adj_bad = !(((pc_i == pv_i + 1) && (pv_i % COLS != COLS - 1)) ||
                          ((pc_i + 1 == pv_i) && (pv_i % COLS != 0)) ||
                          (pc_i == pv_i + COLS) || (pc_i + COLS == pv_i));
`endif
        p_err = !p_in_rng || p_occ || p_full || p_tipo_bad || p_adj_bad;
    end

    // Attack decode
    logic                  a_in_rng, a_att, a_hit, a_sink;
    logic [ID_W-1:0]       a_b;
    logic [MAX_LEN-1:0]    a_newmask, a_fullmask;
    logic [NUM_BARCOS-1:0] hund_n;

    always_comb begin
        a_att      = 1'b0;
        a_hit      = 1'b0;
        a_b        = '0;
        a_newmask  = '0;
        a_fullmask = '0;
        a_in_rng   = int'(attack_casilla) < NUM_CELLS;
        for (int c = 0; c < NUM_CELLS; c++)
            if (attack_casilla == CELL_W'(c))
                a_att = att_q[c];
        // only slots below fill hold real cells; unused slots reset to 0
        for (int b = 0; b < NUM_BARCOS; b++) begin
            for (int s = 0; s < MAX_LEN; s++) begin
                if (s < int'(fill_q[b]) && cell_q[b][s] == attack_casilla) begin
                    a_hit     = 1'b1;
                    a_b       = ID_W'(b);
                    a_newmask = hit_q[b] | (MAX_LEN'(1) << s);
                    for (int s2 = 0; s2 < MAX_LEN; s2++)
                        a_fullmask[s2] = (s2 < int'(len_q[b]));
                end
            end
        end
        a_sink = a_hit && (a_newmask == a_fullmask);
        hund_n = barcos_hundidos;
        for (int b = 0; b < NUM_BARCOS; b++)
            if (a_sink && a_b == ID_W'(b))
                hund_n[b] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st              <= PLACE;
            occ_q           <= '0;
            att_q           <= '0;
            place_ok        <= 1'b0;
            place_err       <= 1'b0;
            attack_done     <= 1'b0;
            hit             <= 1'b0;
            repeat_shot     <= 1'b0;
            sunk            <= 1'b0;
            sunk_id         <= '0;
            barcos_hundidos <= '0;
            all_sunk        <= 1'b0;
            for (int b = 0; b < NUM_BARCOS; b++) begin
                len_q[b]  <= '0;
                fill_q[b] <= '0;
                hit_q[b]  <= '0;
                for (int s = 0; s < MAX_LEN; s++)
                    cell_q[b][s] <= '0;
            end
        end else begin
            place_ok    <= 1'b0;
            place_err   <= 1'b0;
            attack_done <= 1'b0;
            hit         <= 1'b0;
            repeat_shot <= 1'b0;
            sunk        <= 1'b0;
            sunk_id     <= '0;
            case (st)
                PLACE: begin
                    if (place_valid) begin
                        if (p_err) begin
                            place_err <= 1'b1;
                        end else begin
                            place_ok <= 1'b1;
                            for (int c = 0; c < NUM_CELLS; c++)
                                if (place_casilla == CELL_W'(c))
                                    occ_q[c] <= 1'b1;
                            for (int b = 0; b < NUM_BARCOS; b++) begin
                                if (place_barco == ID_W'(b)) begin
                                    if (p_first)
                                        len_q[b] <= tipo;
                                    cell_q[b][fill_q[b]] <= place_casilla;
                                    fill_q[b] <= fill_q[b] + 3'd1;
                                end
                            end
                        end
                    end
                    // registered completeness: transition one edge after the last accept
                    if (all_placed)
                        st <= PLAY;
                end
                PLAY: begin
                    place_err <= place_valid;
                    if (attack_valid) begin
                        attack_done <= 1'b1;
                        if (!a_in_rng || a_att) begin
                            repeat_shot <= 1'b1;
                        end else begin
                            for (int c = 0; c < NUM_CELLS; c++)
                                if (attack_casilla == CELL_W'(c))
                                    att_q[c] <= 1'b1;
                            if (a_hit) begin
                                hit <= 1'b1;
                                for (int b = 0; b < NUM_BARCOS; b++)
                                    if (a_b == ID_W'(b))
                                        hit_q[b] <= a_newmask;
                                if (a_sink) begin
                                    sunk            <= 1'b1;
                                    sunk_id         <= a_b;
                                    barcos_hundidos <= hund_n;
                                    if (&hund_n) begin
                                        st       <= OVER;
                                        all_sunk <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                OVER: begin
                    place_err <= place_valid;
                end
                default: st <= PLACE;
            endcase
        end
    end

endmodule

// File: tb/tb_registro_flota.sv
// Directed bench for registro_flota: each step pushes the expected output
// record to a queue, advances one clock, then pops and compares it.
module tb_registro_flota;

    logic       clk = 1'b0;
    logic       rst;
    logic       place_valid;
    logic [1:0] place_barco;
    logic [4:0] place_casilla;
    logic [2:0] tipo;
    logic       place_ok, place_err;
    logic       attack_valid;
    logic [4:0] attack_casilla;
    logic       attack_done, hit, repeat_shot, sunk;
    logic [1:0] sunk_id;
    logic [2:0] barcos_hundidos;
    logic [1:0] fase;
    logic       all_sunk;

    registro_flota dut (
        .clk(clk), .rst(rst),
        .place_valid(place_valid), .place_barco(place_barco),
        .place_casilla(place_casilla), .tipo(tipo),
        .place_ok(place_ok), .place_err(place_err),
        .attack_valid(attack_valid), .attack_casilla(attack_casilla),
        .attack_done(attack_done), .hit(hit), .repeat_shot(repeat_shot),
        .sunk(sunk), .sunk_id(sunk_id), .barcos_hundidos(barcos_hundidos),
        .fase(fase), .all_sunk(all_sunk)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pok, perr, done, hit, rep, snk;
        logic [1:0] sid;
        logic [2:0] hund;
        logic [1:0] fase;
        logic       all;
    } res_t;

    res_t  exp_q [$];
    string tag_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic res_t ex(input logic pok, perr, done, h, rep, snk,
                                input logic [1:0] sid, input logic [2:0] hund,
                                input logic [1:0] f, input logic all);
        res_t r;
        r = '{pok, perr, done, h, rep, snk, sid, hund, f, all};
        return r;
    endfunction

    function automatic res_t pk(input logic ok, input logic [2:0] hund, input logic [1:0] f);
        return ex(ok, !ok, 0, 0, 0, 0, 2'd0, hund, f, f == 2'b10);
    endfunction

    function automatic res_t at(input logic h, rep, snk, input logic [1:0] sid,
                                input logic [2:0] hund, input logic [1:0] f);
        return ex(0, 0, 1, h, rep, snk, sid, hund, f, f == 2'b10);
    endfunction

    function automatic res_t idle_r(input logic [2:0] hund, input logic [1:0] f);
        return ex(0, 0, 0, 0, 0, 0, 2'd0, hund, f, f == 2'b10);
    endfunction

    task automatic check(input logic strict_sid);
        res_t e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = '{place_ok, place_err, attack_done, hit, repeat_shot, sunk, sunk_id,
              barcos_hundidos, fase, all_sunk};
        if (!strict_sid && !e.snk) begin
            o.sid = 2'd0;
            e.sid = 2'd0;
        end
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", t, o, e);
        end
    endtask

    task automatic cyc(input logic pv, input logic [1:0] pb, input logic [4:0] pc,
                       input logic [2:0] pt, input logic av, input logic [4:0] ac,
                       input res_t e, input string t);
        place_valid    = pv;
        place_barco    = pb;
        place_casilla  = pc;
        tipo           = pt;
        attack_valid   = av;
        attack_casilla = ac;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        place_valid  = 1'b0;
        attack_valid = 1'b0;
        check(1'b0);
    endtask

    task automatic place(input logic [1:0] b, input logic [4:0] c, input logic [2:0] t,
                         input res_t e, input string tg);
        cyc(1'b1, b, c, t, 1'b0, 5'd0, e, tg);
    endtask

    task automatic attack(input logic [4:0] c, input res_t e, input string tg);
        cyc(1'b0, 2'd0, 5'd0, 3'd0, 1'b1, c, e, tg);
    endtask

    task automatic do_reset(input string tg);
        rst = 1'b1;
        exp_q.push_back(idle_r(3'b000, 2'b00));
        tag_q.push_back(tg);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check(1'b1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; place_valid = 1'b0; place_barco = '0; place_casilla = '0;
        tipo = '0; attack_valid = 1'b0; attack_casilla = '0;
        #2;
        do_reset("reset_initial");

`ifdef CONTIGUITY_CHECK_EN
        place(2'd0, 5'd4, 3'd2, pk(1, 3'b000, 2'b00), "contig_first_4");
        place(2'd0, 5'd5, 3'd2, pk(0, 3'b000, 2'b00), "contig_rowwrap_5");
        place(2'd0, 5'd9, 3'd2, pk(1, 3'b000, 2'b00), "contig_below_9");
        do_reset("reset_after_contig");
`endif

        // placement
        place(2'd0, 5'd3,  3'd2, pk(1, 3'b000, 2'b00), "b0_c3");
        place(2'd0, 5'd4,  3'd2, pk(1, 3'b000, 2'b00), "b0_c4");
        place(2'd1, 5'd4,  3'd1, pk(0, 3'b000, 2'b00), "b1_overlap_c4");
        place(2'd1, 5'd10, 3'd1, pk(1, 3'b000, 2'b00), "b1_c10");
        place(2'd0, 5'd5,  3'd2, pk(0, 3'b000, 2'b00), "b0_full");
        place(2'd1, 5'd11, 3'd1, pk(0, 3'b000, 2'b00), "b1_full");
        place(2'd3, 5'd11, 3'd1, pk(0, 3'b000, 2'b00), "barco_range");
        place(2'd2, 5'd25, 3'd3, pk(0, 3'b000, 2'b00), "casilla_range");
        place(2'd2, 5'd11, 3'd0, pk(0, 3'b000, 2'b00), "tipo_zero");
        place(2'd2, 5'd11, 3'd6, pk(0, 3'b000, 2'b00), "tipo_big");
        attack(5'd3, idle_r(3'b000, 2'b00), "attack_in_place");
        place(2'd2, 5'd20, 3'd3, pk(1, 3'b000, 2'b00), "b2_c20");
        place(2'd2, 5'd21, 3'd3, pk(1, 3'b000, 2'b00), "b2_c21");
        place(2'd2, 5'd22, 3'd3, pk(1, 3'b000, 2'b00), "b2_c22");
        attack(5'd20, idle_r(3'b000, 2'b01), "to_play_attack_ignored");

        // attack phase
        attack(5'd20, at(1, 0, 0, 2'd0, 3'b000, 2'b01), "hit_20");
        attack(5'd20, at(0, 1, 0, 2'd0, 3'b000, 2'b01), "repeat_20");
        attack(5'd0,  at(0, 0, 0, 2'd0, 3'b000, 2'b01), "miss_0");
        attack(5'd30, at(0, 1, 0, 2'd0, 3'b000, 2'b01), "range_30");
        place(2'd0, 5'd12, 3'd1, pk(0, 3'b000, 2'b01), "place_in_play");
        cyc(1'b1, 2'd0, 5'd12, 3'd1, 1'b1, 5'd21,
            ex(0, 1, 1, 1, 0, 0, 2'd0, 3'b000, 2'b01, 0), "both_place_attack21");
        attack(5'd22, at(1, 0, 1, 2'd2, 3'b100, 2'b01), "sink_b2");
        attack(5'd3,  at(1, 0, 0, 2'd0, 3'b100, 2'b01), "hit_3");
        attack(5'd4,  at(1, 0, 1, 2'd0, 3'b101, 2'b01), "sink_b0");
        attack(5'd10, at(1, 0, 1, 2'd1, 3'b111, 2'b10), "sink_b1_over");
        attack(5'd5,  idle_r(3'b111, 2'b10), "attack_in_over");
        place(2'd0, 5'd5, 3'd1, pk(0, 3'b111, 2'b10), "place_in_over");

        // second game, reset mid-PLAY
        do_reset("reset_after_over");
        place(2'd0, 5'd3,  3'd1, pk(1, 3'b000, 2'b00), "g2_b0_c3");
        place(2'd1, 5'd4,  3'd1, pk(1, 3'b000, 2'b00), "g2_b1_c4");
        place(2'd2, 5'd20, 3'd1, pk(1, 3'b000, 2'b00), "g2_b2_c20");
        cyc(1'b0, 2'd0, 5'd0, 3'd0, 1'b0, 5'd0, idle_r(3'b000, 2'b01), "g2_to_play");
        attack(5'd3, at(1, 0, 1, 2'd0, 3'b001, 2'b01), "g2_sink_b0");
        do_reset("reset_mid_play");
        place(2'd0, 5'd3, 3'd1, pk(1, 3'b000, 2'b00), "replace_c3");
        place(2'd1, 5'd3, 3'd1, pk(0, 3'b000, 2'b00), "overlap_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/registro_flota.md
Name: registro_flota

Overview:
Parametrised successor to the single-ship register: holds a whole fleet of NUM_BARCOS ships, each up to MAX_LEN cells, for the battleship game datapath. Runs placement (cells loaded one per request, with overlap and range checks), then an attack phase (hit/miss, per-ship sunk tracking, repeat-shot detection), then a game-over hold. Sits between the input/FSM controller and the VGA/score logic.

Parameters:
NUM_BARCOS, 3, number of ships in the fleet
MAX_LEN, 5, maximum ship length in cells
NUM_CELLS, 25, board cells; valid casilla range 0..NUM_CELLS-1
COLS, 5, board columns; used only by the optional contiguity check
CELL_W, 5, casilla width; must satisfy 2**CELL_W >= NUM_CELLS
ID_W, $clog2(NUM_BARCOS) (min 1), ship index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
place_valid  in  1  placement request, one cell
place_barco  in  ID_W  target ship index
place_casilla  in  CELL_W  cell to add to the ship
tipo  in  3  ship length 1..MAX_LEN; sampled only on a ship's first cell
place_ok  out  1  registered pulse: cell accepted
place_err  out  1  registered pulse: cell rejected
attack_valid  in  1  shot request
attack_casilla  in  CELL_W  target cell
attack_done  out  1  registered pulse: shot resolved
hit  out  1  valid with attack_done; shot hit an unhit ship cell
repeat_shot  out  1  valid with attack_done; cell already attacked
sunk  out  1  valid with attack_done; this shot sank a ship
sunk_id  out  ID_W  index of ship sunk (valid when sunk=1)
barcos_hundidos  out  NUM_BARCOS  sunk bitmask
fase  out  2  00 PLACE, 01 PLAY, 10 OVER
all_sunk  out  1  high in OVER

Behaviour:
- Reset (sync, rst=1 at posedge): fase=PLACE; all lengths, fill counts, hit masks, occupied and attacked bitmaps cleared; all pulse outputs, sunk_id, barcos_hundidos, all_sunk = 0. Reset mid-game returns to PLACE with an empty fleet.
- All outputs registered; every request resolves in exactly 1 cycle (pulse on the cycle after the request). No backpressure; one request per cycle.
- PLACE: place_valid accepted (place_ok) unless any error (place_err, no state change):
  - place_barco >= NUM_BARCOS; place_casilla >= NUM_CELLS; cell already occupied by any ship (including the same one);
  - ship already full (fill == len);
  - first cell of ship and tipo==0 or tipo>MAX_LEN.
- On accept: first cell latches len=tipo; cell stored at slot fill; fill++; occupied bit set. Ships may be filled in any order and interleaved.
- PLACE->PLAY on the edge after the cycle in which the final cell of the final incomplete ship is accepted (all fills == their len, all len != 0).
- place_valid in PLAY/OVER -> place_err. attack_valid in PLACE or OVER -> ignored, no attack_done.
- PLAY: attack_valid -> attack_done next cycle. Cell out of range or already in attacked bitmap -> repeat_shot=1, hit=0, no state change. Else attacked bit set; if the cell matches a stored cell of ship k, hit=1 and that slot's hit bit is set; if ship k is now fully hit, sunk=1, sunk_id=k, barcos_hundidos[k] set. Otherwise hit=0 (miss).
- When barcos_hundidos becomes all ones, fase=OVER and all_sunk=1 on the same edge as the final attack_done; hold until rst.
- place_valid and attack_valid together: only the one legal in the current fase acts; the other is handled per the rules above.

Optional Feature:
CONTIGUITY_CHECK_EN: when defined, each non-first cell of a ship must be orthogonally adjacent to the previously accepted cell of that ship (±1 within the same row of COLS, or ±COLS); otherwise place_err. Without it, any free in-range cell is accepted.

Test Plan:
- rst held 2 cycles mid-PLAY -> fase=00, barcos_hundidos=000, all outputs 0, prior cells free to re-place.
- Ship 0 tipo=2 cells 3,4; ship 1 tipo=1 cell 4 -> place_err (overlap); cell 10 -> place_ok; ship 0 third cell 5 -> place_err (full).
- Place ship 2 tipo=3 cells 20,21,22 as last ship -> fase=01 the cycle after the third place_ok; attack in that same cycle -> no attack_done.
- Attack 20 -> hit=1 sunk=0; attack 20 again -> repeat_shot=1 hit=0; attack 0 -> hit=0; attack 30 -> repeat_shot=1.
- Attack 21,22 -> second shot sunk=1 sunk_id=2, barcos_hundidos=100; sink remaining ships -> final attack_done with sunk=1, same edge fase=10, all_sunk=1; further attacks ignored.
- With CONTIGUITY_CHECK_EN: ship 0 first cell 4, then 5 (row wrap) -> place_err; then 9 -> place_ok.
